// File: rtl/spi_seq_pkg.sv
// Shared encodings for the SPI master sequencer: FSM states, SPI command bytes,
// response codes and the fast-read dummy-bit count.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    GAP
  } seq_state_e;

  localparam logic [7:0] CMD_WR      = 8'h02;
  localparam logic [7:0] CMD_RD_SLOW = 8'h03;
  localparam logic [7:0] CMD_RD_FAST = 8'h0B;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int FAST_RD_DUMMY_BITS = 8;

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK phase timer: alternates low/high phases of CLK_DIV cycles while enabled
// and emits one-cycle strobes on the last cycle of each phase.
module spi_sclk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic spi_clk,
  input  logic spi_rst_n,
  input  logic en,
  output logic rise,
  output logic fall,
  output logic sample
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          hi;
  logic          wrap;

  assign wrap = en && (cnt == '0);

  // Disabled means parked at the start of a low phase, so the first phase after
  // enable is always a full low phase.
  always_ff @(posedge spi_clk) begin
    if (!spi_rst_n || !en) begin
      cnt <= RELOAD;
      hi  <= 1'b0;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
      hi  <= ~hi;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign rise   = wrap && !hi;
  assign fall   = wrap && hi;
  assign sample = wrap && hi;

endmodule

// File: rtl/spi_master_sequencer.sv
// Sequences one mode-0 SPI frame (cmd, address, data) per bridge word request.
// Define SPI_SEQ_FAST_READ_EN for fast reads (cmd 0x0B plus 8 dummy bits).
module spi_master_sequencer
  import spi_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 24,
  parameter int CLK_DIV    = 2
) (
  input  logic                  spi_clk,
  input  logic                  spi_rst_n,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wr_data,
  input  logic [3:0]            req_wr_strb,
  input  logic                  req_wr_valid,
  input  logic                  req_rd_valid,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] rsp_rd_data,
  output logic                  rsp_rd_done,
  output logic                  rsp_wr_done,
  output logic [1:0]            rsp_resp,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

`ifdef SPI_SEQ_FAST_READ_EN
  localparam logic [7:0] CMD_RD     = CMD_RD_FAST;
  localparam int         DUMMY_BITS = FAST_RD_DUMMY_BITS;
`else
  localparam logic [7:0] CMD_RD     = CMD_RD_SLOW;
  localparam int         DUMMY_BITS = 0;
`endif

  localparam int WR_BITS = 8 + ADDR_BITS + DATA_WIDTH;
  localparam int RD_BITS = WR_BITS + DUMMY_BITS;
  localparam int TX_W    = RD_BITS;
  localparam int BCW     = $clog2(TX_W + 1);

  seq_state_e            state, state_nxt;
  logic                  is_rd;
  logic [1:0]            resp_q;
  logic [BCW-1:0]        bit_cnt;
  logic [TX_W-1:0]       tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  accept, no_xfer;
  logic                  div_en, rise, fall, sample;
  logic [WR_BITS-1:0]    wr_frame, rd_frame;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:ADDR_BITS];

  assign accept   = req_ready && (req_wr_valid || req_rd_valid);
  assign no_xfer  = req_wr_valid && (req_wr_strb != 4'hF);
  assign wr_frame = {CMD_WR, req_addr[ADDR_BITS-1:0], req_wr_data};
  assign rd_frame = {CMD_RD, req_addr[ADDR_BITS-1:0], {DATA_WIDTH{1'b0}}};
  assign div_en   = (state == SETUP) || (state == SHIFT) || (state == GAP);
  assign rsp_resp = resp_q;

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .spi_clk  (spi_clk),
    .spi_rst_n(spi_rst_n),
    .en       (div_en),
    .rise     (rise),
    .fall     (fall),
    .sample   (sample)
  );

  always_comb begin
    state_nxt   = state;
    cs_n        = 1'b1;
    mosi        = 1'b0;
    rsp_wr_done = 1'b0;
    rsp_rd_done = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = no_xfer ? DONE : SETUP;
      SETUP:   if (rise) state_nxt = SHIFT;
      SHIFT:   if (rise && bit_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = GAP;
      GAP:     if (rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state == SETUP || state == SHIFT) begin
      cs_n = 1'b0;
      mosi = tx_sr[TX_W-1];
    end
    if (state == DONE) begin
      rsp_rd_done = is_rd;
      rsp_wr_done = !is_rd;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (!spi_rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      sclk        <= 1'b0;
      is_rd       <= 1'b0;
      resp_q      <= RESP_OKAY;
      bit_cnt     <= '0;
      rsp_rd_data <= '0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == IDLE);
      if (accept) begin
        // Write wins when both are raised; the read stays pending upstream.
        is_rd   <= !req_wr_valid;
        bit_cnt <= req_wr_valid ? BCW'(WR_BITS) : BCW'(RD_BITS);
        resp_q  <= (no_xfer && req_wr_strb != 4'h0) ? RESP_SLVERR : RESP_OKAY;
      end else if (state == SHIFT && fall) begin
        bit_cnt <= bit_cnt - BCW'(1);
      end
      // A rise strobe with no bits left is the end of the cs hold phase, not a new bit.
      if (rise && (state == SETUP || (state == SHIFT && bit_cnt != '0))) begin
        sclk <= 1'b1;
      end else if (fall || state_nxt != SHIFT) begin
        sclk <= 1'b0;
      end
      if (state == SHIFT && state_nxt == DONE && is_rd) begin
        rsp_rd_data <= rx_sr;
      end
    end
  end

  // The last DATA_WIDTH samples of a read frame are the data phase.
  always_ff @(posedge spi_clk) begin
    if (accept) begin
      tx_sr <= req_wr_valid ? (TX_W'(wr_frame) << DUMMY_BITS) : (TX_W'(rd_frame) << DUMMY_BITS);
    end else if (state == SHIFT && fall) begin
      tx_sr <= tx_sr << 1;
    end
    if (state == SHIFT && sample) begin
      rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
    end
  end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed plus randomized bench for spi_master_sequencer (CLK_DIV=2 and CLK_DIV=1 instances).
module tb_spi_master_sequencer;

`ifdef SPI_SEQ_FAST_READ_EN
  localparam logic [7:0] RD_CMD   = 8'h0B;
  localparam int         RD_DUMMY = 8;
`else
  localparam logic [7:0] RD_CMD   = 8'h03;
  localparam int         RD_DUMMY = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel, wr_valid, rd_valid;
  logic        miso = 1'b0;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;
  logic        wv0, rv0, wv1, rv1;
  logic        ready0, rdd0, wd0, sclk0, cs_n0, mosi0;
  logic        ready1, rdd1, wd1, sclk1, cs_n1, mosi1;
  logic [1:0]  resp0, resp1;
  logic [31:0] rdata0, rdata1;

  assign wv0 = wr_valid & ~sel;
  assign rv0 = rd_valid & ~sel;
  assign wv1 = wr_valid & sel;
  assign rv1 = rd_valid & sel;

  spi_master_sequencer #(.CLK_DIV(2)) u0 (
    .spi_clk(clk), .spi_rst_n(rst_n), .req_addr(addr), .req_wr_data(wdata),
    .req_wr_strb(strb), .req_wr_valid(wv0), .req_rd_valid(rv0), .req_ready(ready0),
    .rsp_rd_data(rdata0), .rsp_rd_done(rdd0), .rsp_wr_done(wd0), .rsp_resp(resp0),
    .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso));

  spi_master_sequencer #(.CLK_DIV(1)) u1 (
    .spi_clk(clk), .spi_rst_n(rst_n), .req_addr(addr), .req_wr_data(wdata),
    .req_wr_strb(strb), .req_wr_valid(wv1), .req_rd_valid(rv1), .req_ready(ready1),
    .rsp_rd_data(rdata1), .rsp_rd_done(rdd1), .rsp_wr_done(wd1), .rsp_resp(resp1),
    .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso));

  // Observed view of whichever instance is under test.
  logic        m_cs_n, m_sclk, m_mosi, m_ready, m_wd, m_rdd;
  logic [1:0]  m_resp;
  logic [31:0] m_rdata;
  assign m_cs_n  = sel ? cs_n1  : cs_n0;
  assign m_sclk  = sel ? sclk1  : sclk0;
  assign m_mosi  = sel ? mosi1  : mosi0;
  assign m_ready = sel ? ready1 : ready0;
  assign m_wd    = sel ? wd1    : wd0;
  assign m_rdd   = sel ? rdd1   : rdd0;
  assign m_resp  = sel ? resp1  : resp0;
  assign m_rdata = sel ? rdata1 : rdata0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         prev_sclk = 1'b0, prev_cs = 1'b1, prev_ready = 1'b0;
  int           rise_cnt = 0, cs_falls = 0, cs_fall_cyc = 0, hi_run = 0, last_hi_run = 0;
  int           acc_cyc = 0, done_cnt = 0, done_cyc = 0, ready_rise_cyc = 0;
  logic         done_wr = 1'b0;
  logic [1:0]   done_resp = 2'b00;
  logic [31:0]  done_rdata = '0;
  logic [127:0] cap = '0;
  logic [31:0]  slave_word = '0;
  int           exp_n = 64;

  // Bus monitor and mode-0 slave: MOSI is captured at each SCLK rise; MISO
  // presents the slave word during the last 32 bits and noise before that.
  always @(negedge clk) begin
    prev_sclk  <= m_sclk;
    prev_cs    <= m_cs_n;
    prev_ready <= m_ready;
    hi_run     <= m_cs_n ? hi_run + 1 : 0;
    if (prev_cs && !m_cs_n) begin
      cs_falls    <= cs_falls + 1;
      cs_fall_cyc <= cyc;
      last_hi_run <= hi_run;
      rise_cnt    <= 0;
      cap         <= '0;
    end
    if (!prev_sclk && m_sclk) begin
      cap      <= {cap[126:0], m_mosi};
      rise_cnt <= rise_cnt + 1;
      if (rise_cnt >= exp_n - 32) miso <= slave_word[5'(exp_n - 1 - rise_cnt)];
      else miso <= 1'($urandom);
    end
    if (m_ready && (wr_valid || rd_valid)) acc_cyc <= cyc;
    if (m_wd || m_rdd) begin
      done_cnt   <= done_cnt + 1;
      done_cyc   <= cyc;
      done_wr    <= m_wd;
      done_resp  <= m_resp;
      done_rdata <= m_rdata;
    end
    if (!prev_ready && m_ready) ready_rise_cyc <= cyc;
  end

  int          checks = 0, errors = 0;
  logic [31:0] last_rd = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 3000) begin
      step();
      n++;
    end
    check("done_seen", 128'(done_cnt), 128'(prev + 1));
  endtask

  function automatic logic [127:0] exp_frame(input bit is_wr, input logic [31:0] a, input logic [31:0] d);
    logic [127:0] f;
    f = 128'({(is_wr ? 8'h02 : RD_CMD), a[23:0]});
    if (is_wr) f = (f << 32) | 128'(d);
    else f = f << (32 + RD_DUMMY);
    return f;
  endfunction

  task automatic txn(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] sw);
    int         prev_done  = done_cnt;
    int         prev_falls = cs_falls;
    int         cd         = sel ? 1 : 2;
    int         n          = is_wr ? 64 : 64 + RD_DUMMY;
    bit         xfer       = !is_wr || (s == 4'hF);
    logic [1:0] er         = (is_wr && s != 4'hF && s != 4'h0) ? 2'b10 : 2'b00;
    addr = a; wdata = d; strb = s; slave_word = sw; exp_n = n;
    wr_valid = is_wr;
    rd_valid = !is_wr;
    wait_done(prev_done);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    check("done_dir", 128'(done_wr), 128'(is_wr));
    check("resp", 128'(done_resp), 128'(er));
    check("latency", 128'(done_cyc - acc_cyc), 128'(xfer ? 1 + cd * (1 + 2 * n) : 1));
    if (xfer) begin
      check("cs_fall", 128'(cs_fall_cyc - acc_cyc), 128'(1));
      check("nbits", 128'(rise_cnt), 128'(n));
      check("frame", cap, exp_frame(is_wr, a, d));
    end else begin
      check("no_cs", 128'(cs_falls), 128'(prev_falls));
    end
    if (!is_wr) last_rd = sw;
    check("rd_data", 128'(done_rdata), 128'(last_rd));
  endtask

  initial begin
    int prev, falls, d1, n;
    sel = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    addr = '0; wdata = '0; strb = '0; rst_n = 1'b0;
    repeat (3) step();
    check("rst_cs_n", 128'(cs_n0), 128'(1));
    check("rst_sclk", 128'(sclk0), 128'(0));
    check("rst_mosi", 128'(mosi0), 128'(0));
    check("rst_ready", 128'(ready0), 128'(0));
    check("rst_dones", 128'({wd0, rdd0}), 128'(0));
    check("rst_resp", 128'(resp0), 128'(0));
    check("rst_rdata", 128'(rdata0), 128'(0));
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 128'(ready0), 128'(1));

    txn(1'b1, 32'h0012_3456, 32'hDEAD_BEEF, 4'hF, 32'h0);
    txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'hCAFE_F00D);
    txn(1'b1, 32'h0000_1000, 32'h1111_2222, 4'h3, 32'h0);
    txn(1'b1, 32'h0000_2000, 32'h3333_4444, 4'h0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      int         kind;
      logic [3:0] s;
      kind = $urandom_range(0, 3);
      s = (kind == 3) ? 4'($urandom_range(0, 15)) : 4'hF;
      txn(kind != 2, $urandom, $urandom, s, $urandom);
    end

    // Simultaneous write and read: write frame first, read served after the gap.
    prev = done_cnt;
    addr = 32'h00AB_CDEF; wdata = $urandom; strb = 4'hF; exp_n = 64; slave_word = $urandom;
    wr_valid = 1'b1; rd_valid = 1'b1;
    wait_done(prev);
    wr_valid = 1'b0;
    check("arb_first_wr", 128'(done_wr), 128'(1));
    check("arb_wr_frame", cap, exp_frame(1'b1, addr, wdata));
    d1 = done_cyc;
    exp_n = 64 + RD_DUMMY;
    wait_done(prev + 1);
    rd_valid = 1'b0;
    check("arb_second_rd", 128'(done_wr), 128'(0));
    check("arb_ready_gap", 128'(ready_rise_cyc - d1), 128'(1 + 2));
    check("arb_rd_accept", 128'(acc_cyc), 128'(ready_rise_cyc));
    check("arb_rd_frame", cap, exp_frame(1'b0, addr, 32'h0));
    check("arb_rd_data", 128'(done_rdata), 128'(slave_word));
    last_rd = slave_word;

    // Reset pulse in the middle of a write frame.
    prev = done_cnt;
    addr = 32'h0055_AA55; wdata = 32'hFFFF_FFFF; strb = 4'hF; exp_n = 64;
    wr_valid = 1'b1;
    n = 0;
    while (rise_cnt != 20 && n < 2000) begin
      step();
      n++;
    end
    check("reach_bit20", 128'(rise_cnt), 128'(20));
    rst_n = 1'b0;
    wr_valid = 1'b0;
    step();
    check("mid_rst_cs_n", 128'(cs_n0), 128'(1));
    check("mid_rst_sclk", 128'(sclk0), 128'(0));
    check("mid_rst_mosi", 128'(mosi0), 128'(0));
    check("mid_rst_ready", 128'(ready0), 128'(0));
    check("mid_rst_rdata", 128'(rdata0), 128'(0));
    rst_n = 1'b1;
    last_rd = '0;
    repeat (20) step();
    check("mid_rst_no_done", 128'(done_cnt), 128'(prev));
    txn(1'b1, 32'h0000_0ABC, 32'h0BAD_F00D, 4'hF, 32'h0);

    // CLK_DIV=1 instance: back-to-back writes with valid held until done.
    sel = 1'b1;
    last_rd = '0;
    repeat (4) step();
    prev = done_cnt;
    falls = cs_falls;
    txn(1'b1, 32'h0001_0203, 32'h0405_0607, 4'hF, 32'h0);
    txn(1'b1, 32'h0008_090A, 32'h0B0C_0D0E, 4'hF, 32'h0);
    check("b2b_frames", 128'(cs_falls - falls), 128'(2));
    check("b2b_dones", 128'(done_cnt - prev), 128'(2));
    check("b2b_cs_high", 128'(last_hi_run), 128'(2 + 1));
    repeat (10) step();
    check("b2b_no_extra", 128'(done_cnt - prev), 128'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
